sirv_reset_sequencer: RTL and testbench



---
 rtl/sirv_reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_sirv_reset_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_reset_sequencer.sv
// Reset-release sequencer for the always-on region: merges external, watchdog and
// software reset requests, holds all stages in reset, then releases them in order.
module sirv_reset_sequencer #(
   parameter int NSTAGE = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              test_mode,
   input  logic              ext_rst_sync,
   input  logic              wdog_rst_req,
   input  logic              sw_rst_req,
   input  logic [CNT_W-1:0]  hold_cfg,
   input  logic [NSTAGE-1:0] stage_ack,
   input  logic              cause_clr,
   output logic [NSTAGE-1:0] stage_rst,
   output logic              busy,
   output logic [2:0]        cause,
   output logic              ack_timeout,
   output logic [1:0]        dbg_state
);

   localparam int IDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ASSERT = 2'd1,
      ST_REL    = 2'd2,
      ST_WAIT   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSTAGE-1:0]  stage_rst_q, stage_rst_d;
   logic               busy_q, busy_d;
   logic [2:0]         cause_q, cause_d;
   logic               ack_timeout_q, ack_timeout_d;

   logic               req;
   logic [CNT_W-1:0]   hold_len;
   logic               last_stage;
   logic               cur_ack;
   logic               tmo_evt;
   logic [NSTAGE-1:0]  rel_mask;

   assign req        = ext_rst_sync | wdog_rst_req | sw_rst_req;
   assign hold_len   = (hold_cfg == '0) ? CNT_W'(1) : hold_cfg;
   assign last_stage = (idx_q == IDX_W'(NSTAGE - 1));
   assign cur_ack    = stage_ack[idx_q];

   // Stages at or below the current index are released; the rest stay in reset.
   always_comb begin
      rel_mask = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         rel_mask[i] = (i > int'(idx_q));
      end
   end

   // Stage handshake: stage_rst[k] falling is the release request; stage_ack[k]
   // high is the response and is only sampled while waiting on stage k.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tmo_evt = 1'b0;
      if (req) begin
         state_d = ST_ASSERT;
         idx_d   = '0;
         cnt_d   = hold_len;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_REL;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_REL: begin
               cnt_d   = '1;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (!cur_ack) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
               if (cur_ack || (cnt_q <= CNT_W'(1))) begin
                  tmo_evt = !cur_ack;
                  if (last_stage) begin
                     state_d = ST_RUN;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = ST_REL;
                  end
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_ASSERT;
               cnt_d   = hold_len;
            end
         endcase
      end
   end

   // Outputs are registered from the current state, so they trail it by a cycle.
   always_comb begin
      stage_rst_d = '1;
      case (state_q)
         ST_ASSERT: stage_rst_d = '1;
         ST_REL:    stage_rst_d = rel_mask;
         ST_WAIT:   stage_rst_d = rel_mask;
         ST_RUN:    stage_rst_d = '0;
         default:   stage_rst_d = '1;
      endcase
      busy_d        = (state_q != ST_RUN);
      cause_d       = (cause_clr ? 3'b000 : cause_q) | {sw_rst_req, wdog_rst_req, ext_rst_sync};
      ack_timeout_d = (ack_timeout_q & ~cause_clr) | tmo_evt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_ASSERT;
         idx_q         <= '0;
         cnt_q         <= CNT_W'(1);
         stage_rst_q   <= '1;
         busy_q        <= 1'b1;
         cause_q       <= 3'b001;
         ack_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         stage_rst_q   <= stage_rst_d;
         busy_q        <= busy_d;
         cause_q       <= cause_d;
         ack_timeout_q <= ack_timeout_d;
      end
   end

   // Scan bypass: external reset drives every stage directly.
   assign stage_rst   = test_mode ? {NSTAGE{ext_rst_sync}} : stage_rst_q;
   assign busy        = busy_q;
   assign cause       = cause_q;
   assign ack_timeout = ack_timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_sirv_reset_sequencer.sv
// Bench for sirv_reset_sequencer: a hand-derived vector table, directed corner
// sequences and randomized traffic against an episode-level reference model.
module tb_sirv_reset_sequencer;

   localparam int NSTAGE = 3;
   localparam int CNT_W  = 8;
   localparam int TMO    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, test_mode, ext_rst_sync, wdog_rst_req, sw_rst_req, cause_clr;
   logic [CNT_W-1:0]  hold_cfg;
   logic [NSTAGE-1:0] stage_ack;
   logic [NSTAGE-1:0] stage_rst;
   logic              busy;
   logic [2:0]        cause;
   logic              ack_timeout;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   sirv_reset_sequencer #(.NSTAGE(NSTAGE), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .test_mode    (test_mode),
      .ext_rst_sync (ext_rst_sync),
      .wdog_rst_req (wdog_rst_req),
      .sw_rst_req   (sw_rst_req),
      .hold_cfg     (hold_cfg),
      .stage_ack    (stage_ack),
      .cause_clr    (cause_clr),
      .stage_rst    (stage_rst),
      .busy         (busy),
      .cause        (cause),
      .ack_timeout  (ack_timeout),
      .dbg_state    (dbg_state)
   );

   // Reference model: an episode is "holding", "releasing stage k", "waiting on
   // stage k" or "running"; hold and wait times are counted upward in cycles.
   typedef enum int {P_RUN, P_HOLD, P_REL, P_WAIT} phase_e;
   phase_e      m_phase;
   int          m_stage, m_elapsed, m_target, m_waited;
   logic [2:0]  m_rst;
   logic        m_busy;
   logic [2:0]  m_cause;
   logic        m_to;

   function automatic logic [2:0] model_mask();
      int v;
      case (m_phase)
         P_HOLD:  v = (1 << NSTAGE) - 1;
         P_RUN:   v = 0;
         default: v = ((1 << NSTAGE) - 1) & ~((1 << (m_stage + 1)) - 1);
      endcase
      return 3'(v);
   endfunction

   task automatic model_advance(output logic done);
      done = 1'b1;
      if (m_stage == NSTAGE - 1) m_phase = P_RUN;
      else begin
         m_stage = m_stage + 1;
         m_phase = P_REL;
      end
   endtask

   task automatic model_edge();
      logic [2:0] nxt_rst;
      logic       nxt_busy, to_evt, req, adv;
      if (!rst_n) begin
         m_phase = P_HOLD; m_target = 1; m_elapsed = 0; m_stage = 0;
         m_rst = 3'b111; m_busy = 1'b1; m_cause = 3'b001; m_to = 1'b0;
         return;
      end
      nxt_rst  = model_mask();
      nxt_busy = (m_phase != P_RUN);
      req      = ext_rst_sync | wdog_rst_req | sw_rst_req;
      m_cause  = (cause_clr ? 3'b000 : m_cause) | {sw_rst_req, wdog_rst_req, ext_rst_sync};
      to_evt   = 1'b0;
      adv      = 1'b0;
      if (req) begin
         m_phase   = P_HOLD;
         m_target  = (hold_cfg == 0) ? 1 : int'(hold_cfg);
         m_elapsed = 0;
      end else begin
         case (m_phase)
            P_HOLD: begin
               m_elapsed++;
               if (m_elapsed >= m_target) begin
                  m_phase = P_REL;
                  m_stage = 0;
               end
            end
            P_REL: begin
               m_phase  = P_WAIT;
               m_waited = 0;
            end
            P_WAIT: begin
               if (stage_ack[m_stage]) model_advance(adv);
               else begin
                  m_waited++;
                  if (m_waited == TMO) begin
                     to_evt = 1'b1;
                     model_advance(adv);
                  end
               end
            end
            default: ;
         endcase
      end
      m_to   = (cause_clr ? 1'b0 : m_to) | to_evt;
      m_rst  = nxt_rst;
      m_busy = nxt_busy;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [2:0] exp_rst;
      exp_rst = test_mode ? {NSTAGE{ext_rst_sync}} : m_rst;
      check("model_stage_rst", 8'(stage_rst), 8'(exp_rst));
      check("model_busy", 8'(busy), 8'(m_busy));
      check("model_cause", 8'(cause), 8'(m_cause));
      check("model_ack_timeout", 8'(ack_timeout), 8'(m_to));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic wait_until(input phase_e ph, input int stg, input int budget, input string name);
      int n;
      n = 0;
      while (!(m_phase == ph && m_stage == stg) && n < budget) begin
         step();
         n++;
      end
      n_checks++;
      if (!(m_phase == ph && m_stage == stg)) begin
         n_errors++;
         $display("FAIL %s: phase not reached within %0d cycles (phase %0d stage %0d)",
                  name, budget, m_phase, m_stage);
      end
   endtask

   typedef struct {
      logic       rst_n, ext, sw, tm;
      logic [7:0] hold;
      logic [2:0] e_rst;
      logic       e_busy;
      logic [2:0] e_cause;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   function automatic vec_t mk(logic r, logic e, logic s, logic t, logic [7:0] h,
                               logic [2:0] er, logic eb, logic [2:0] ec);
      vec_t v;
      v.rst_n = r; v.ext = e; v.sw = s; v.tm = t; v.hold = h;
      v.e_rst = er; v.e_busy = eb; v.e_cause = ec;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Power-on with hold 4, release as ext falls; then sw pulse with hold 0;
      // then a short test_mode excursion. Acks are all high throughout.
      vecs[0]  = mk(0, 1, 0, 0, 4, 3'b111, 1, 3'b001);
      vecs[1]  = mk(1, 1, 0, 0, 4, 3'b111, 1, 3'b001);
      vecs[2]  = mk(1, 0, 0, 0, 4, 3'b111, 1, 3'b001);
      vecs[3]  = mk(1, 0, 0, 0, 4, 3'b111, 1, 3'b001);
      vecs[4]  = mk(1, 0, 0, 0, 4, 3'b111, 1, 3'b001);
      vecs[5]  = mk(1, 0, 0, 0, 4, 3'b111, 1, 3'b001);
      vecs[6]  = mk(1, 0, 0, 0, 4, 3'b110, 1, 3'b001);
      vecs[7]  = mk(1, 0, 0, 0, 4, 3'b110, 1, 3'b001);
      vecs[8]  = mk(1, 0, 0, 0, 4, 3'b100, 1, 3'b001);
      vecs[9]  = mk(1, 0, 0, 0, 4, 3'b100, 1, 3'b001);
      vecs[10] = mk(1, 0, 0, 0, 4, 3'b000, 1, 3'b001);
      vecs[11] = mk(1, 0, 0, 0, 4, 3'b000, 1, 3'b001);
      vecs[12] = mk(1, 0, 0, 0, 4, 3'b000, 0, 3'b001);
      vecs[13] = mk(1, 0, 1, 0, 0, 3'b000, 0, 3'b101);
      vecs[14] = mk(1, 0, 0, 0, 0, 3'b111, 1, 3'b101);
      vecs[15] = mk(1, 0, 0, 0, 0, 3'b110, 1, 3'b101);
      vecs[16] = mk(1, 0, 0, 0, 0, 3'b110, 1, 3'b101);
      vecs[17] = mk(1, 0, 0, 0, 0, 3'b100, 1, 3'b101);
      vecs[18] = mk(1, 0, 0, 0, 0, 3'b100, 1, 3'b101);
      vecs[19] = mk(1, 0, 0, 0, 0, 3'b000, 1, 3'b101);
      vecs[20] = mk(1, 0, 0, 0, 0, 3'b000, 1, 3'b101);
      vecs[21] = mk(1, 0, 0, 0, 0, 3'b000, 0, 3'b101);
      vecs[22] = mk(1, 1, 0, 1, 0, 3'b111, 0, 3'b101);
      vecs[23] = mk(1, 0, 0, 1, 0, 3'b000, 1, 3'b101);
      vecs[24] = mk(1, 0, 0, 0, 0, 3'b110, 1, 3'b101);

      rst_n = 1'b0; test_mode = 1'b0; ext_rst_sync = 1'b1; wdog_rst_req = 1'b0;
      sw_rst_req = 1'b0; cause_clr = 1'b0; hold_cfg = 8'd4; stage_ack = 3'b111;

      for (int i = 0; i < NV; i++) begin
         rst_n = vecs[i].rst_n; ext_rst_sync = vecs[i].ext; sw_rst_req = vecs[i].sw;
         test_mode = vecs[i].tm; hold_cfg = vecs[i].hold;
         wdog_rst_req = 1'b0; cause_clr = 1'b0; stage_ack = 3'b111;
         step();
         check($sformatf("tbl%0d_stage_rst", i), 8'(stage_rst), 8'(vecs[i].e_rst));
         check($sformatf("tbl%0d_busy", i), 8'(busy), 8'(vecs[i].e_busy));
         check($sformatf("tbl%0d_cause", i), 8'(cause), 8'(vecs[i].e_cause));
         check($sformatf("tbl%0d_ack_timeout", i), 8'(ack_timeout), 8'd0);
      end

      // Stage 1 never acknowledges: WAIT(1) must last exactly TMO cycles.
      stage_ack = 3'b101;
      step();
      step();
      for (int i = 0; i < TMO - 1; i++) step();
      check("tmo_not_yet", 8'(ack_timeout), 8'd0);
      step();
      check("tmo_set", 8'(ack_timeout), 8'd1);
      for (int i = 0; i < 10; i++) step();
      check("tmo_stage_rst_released", 8'(stage_rst), 8'd0);
      check("tmo_busy_low", 8'(busy), 8'd0);
      check("tmo_cause_kept", 8'(cause), 8'b101);
      cause_clr = 1'b1;
      step();
      cause_clr = 1'b0;
      check("clr_cause", 8'(cause), 8'd0);
      check("clr_ack_timeout", 8'(ack_timeout), 8'd0);

      // Watchdog request while waiting on stage 2.
      hold_cfg = 8'd2; stage_ack = 3'b011; sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      wait_until(P_WAIT, 2, 40, "reach_wait2");
      for (int i = 0; i < 3; i++) step();
      wdog_rst_req = 1'b1;
      step();
      step();
      check("wdog_reassert", 8'(stage_rst), 8'b111);
      check("wdog_cause", 8'(cause), 8'b110);
      wdog_rst_req = 1'b0;
      step();
      step();
      check("wdog_hold_end", 8'(stage_rst), 8'b111);
      step();
      check("wdog_rel0", 8'(stage_rst), 8'b110);

      // Synchronous reset in the middle of releasing stage 1.
      wait_until(P_REL, 1, 10, "reach_rel1");
      rst_n = 1'b0;
      step();
      check("midrst_stage_rst", 8'(stage_rst), 8'b111);
      check("midrst_busy", 8'(busy), 8'd1);
      check("midrst_cause", 8'(cause), 8'b001);
      check("midrst_ack_timeout", 8'(ack_timeout), 8'd0);
      rst_n = 1'b1; hold_cfg = 8'd3; stage_ack = 3'b111;
      step();
      check("restart_assert", 8'(stage_rst), 8'b111);
      for (int i = 0; i < 12; i++) step();
      check("restart_done_busy", 8'(busy), 8'd0);

      // Randomized traffic; a quiet window with stage 1 stuck forces timeouts.
      for (int c = 0; c < 3000; c++) begin
         logic quiet;
         quiet = (c >= 1500 && c < 2100);
         rst_n        = quiet ? 1'b1 : ($urandom_range(0, 299) != 0);
         ext_rst_sync = quiet ? 1'b0 : ($urandom_range(0, 79) == 0);
         wdog_rst_req = quiet ? 1'b0 : ($urandom_range(0, 79) == 0);
         sw_rst_req   = quiet ? 1'b0 : ($urandom_range(0, 79) == 0);
         cause_clr    = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) test_mode = ~test_mode;
         hold_cfg = 8'($urandom_range(0, 6));
         for (int b = 0; b < NSTAGE; b++) stage_ack[b] = ($urandom_range(0, 3) != 0);
         if (quiet) stage_ack[1] = 1'b0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
